// File: rtl/axi_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// axi_arbiter_2x1
// Two-master to one-slave AXI3-style arbiter. The write path (AW/W/B) and the
// read path (AR/R) each have their own small FSM. A path is owned by one
// master from its address request until its last response beat. The two paths
// may be owned at the same time. After each completed transaction the loser
// gets priority for the next simultaneous request.
//
// Ports
//   aclk, areset          : single clock, synchronous active-high reset
//   mN_aw* / mN_awready   : write-address channel of master N (N = 0, 1)
//   mN_w*  / mN_wready    : write-data channel of master N
//   mN_b*  / mN_bready    : write-response channel of master N
//   mN_ar* / mN_arready   : read-address channel of master N
//   mN_r*  / mN_rready    : read-data channel of master N
//   s_*                   : slave side. IDs are widened to 5 bits, and the MSB
//                           carries the owning master index.
//   wr_busy, rd_busy      : path currently owned
//   wr_grant, rd_grant    : index of the current (or last) owner
// -----------------------------------------------------------------------------
module axi_arbiter_2x1 #(
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic        aclk,
  input  logic        areset,
  // master 0
  input  logic [31:0] m0_awaddr,
  input  logic [3:0]  m0_awid,
  input  logic [3:0]  m0_awlen,
  input  logic [2:0]  m0_awsize,
  input  logic [1:0]  m0_awburst,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [3:0]  m0_wid,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wlast,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [3:0]  m0_bid,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [3:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [3:0]  m0_rid,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // master 1
  input  logic [31:0] m1_awaddr,
  input  logic [3:0]  m1_awid,
  input  logic [3:0]  m1_awlen,
  input  logic [2:0]  m1_awsize,
  input  logic [1:0]  m1_awburst,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [3:0]  m1_wid,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wlast,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [3:0]  m1_bid,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [3:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [3:0]  m1_rid,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // slave
  output logic [31:0] s_awaddr,
  output logic [4:0]  s_awid,
  output logic [3:0]  s_awlen,
  output logic [2:0]  s_awsize,
  output logic [1:0]  s_awburst,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [4:0]  s_wid,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wlast,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [4:0]  s_bid,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,
  output logic [31:0] s_araddr,
  output logic [4:0]  s_arid,
  output logic [3:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [4:0]  s_rid,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rlast,
  input  logic        s_rvalid,
  output logic        s_rready,
  // status
  output logic        wr_busy,
  output logic        rd_busy,
  output logic        wr_grant,
  output logic        rd_grant
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2
  } rd_state_t;

  wr_state_t wr_state_r, wr_state_nxt_s;
  rd_state_t rd_state_r, rd_state_nxt_s;
  logic      wr_grant_r, wr_grant_nxt_s, wr_pri_r, wr_pri_nxt_s;
  logic      rd_grant_r, rd_grant_nxt_s, rd_pri_r, rd_pri_nxt_s;
  logic      wr_win_s, rd_win_s;

  // Routing back to a master is decided by the registered grant, so the
  // owner bit the slave echoes in its ID MSB is not needed.
  logic unused_id_msb_s;
  assign unused_id_msb_s = s_bid[4] ^ s_rid[4];

  // Arbitration winners: a lone requester wins, a tie goes to the priority index.
  always_comb begin
    wr_win_s = (m0_awvalid && m1_awvalid) ? wr_pri_r : m1_awvalid;
    rd_win_s = (m0_arvalid && m1_arvalid) ? rd_pri_r : m1_arvalid;
  end

  // State, grant and priority registers for both paths.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_r <= W_IDLE;
      rd_state_r <= R_IDLE;
      wr_grant_r <= 1'b0;
      rd_grant_r <= 1'b0;
      wr_pri_r   <= FIRST_PRI;
      rd_pri_r   <= FIRST_PRI;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      rd_state_r <= rd_state_nxt_s;
      wr_grant_r <= wr_grant_nxt_s;
      rd_grant_r <= rd_grant_nxt_s;
      wr_pri_r   <= wr_pri_nxt_s;
      rd_pri_r   <= rd_pri_nxt_s;
    end
  end

  // Write path next-state: grant on request, then advance on each handshake.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    wr_grant_nxt_s = wr_grant_r;
    wr_pri_nxt_s   = wr_pri_r;
    case (wr_state_r)
      W_IDLE: begin
        if (m0_awvalid || m1_awvalid) begin
          wr_grant_nxt_s = wr_win_s;
          wr_state_nxt_s = W_ADDR;
        end else begin
          wr_state_nxt_s = W_IDLE;
        end
      end
      W_ADDR: begin
        if (s_awvalid && s_awready) wr_state_nxt_s = W_DATA;
        else                        wr_state_nxt_s = W_ADDR;
      end
      W_DATA: begin
        if (s_wvalid && s_wready && s_wlast) wr_state_nxt_s = W_RESP;
        else                                 wr_state_nxt_s = W_DATA;
      end
      W_RESP: begin
        if (s_bvalid && s_bready) begin
          wr_state_nxt_s = W_IDLE;
          wr_pri_nxt_s   = ~wr_grant_r;
        end else begin
          wr_state_nxt_s = W_RESP;
        end
      end
      default: wr_state_nxt_s = W_IDLE;
    endcase
  end

  // Read path next-state: same grant scheme; the last R beat releases the path.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    rd_grant_nxt_s = rd_grant_r;
    rd_pri_nxt_s   = rd_pri_r;
    case (rd_state_r)
      R_IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          rd_grant_nxt_s = rd_win_s;
          rd_state_nxt_s = R_ADDR;
        end else begin
          rd_state_nxt_s = R_IDLE;
        end
      end
      R_ADDR: begin
        if (s_arvalid && s_arready) rd_state_nxt_s = R_DATA;
        else                        rd_state_nxt_s = R_ADDR;
      end
      R_DATA: begin
        if (s_rvalid && s_rready && s_rlast) begin
          rd_state_nxt_s = R_IDLE;
          rd_pri_nxt_s   = ~rd_grant_r;
        end else begin
          rd_state_nxt_s = R_DATA;
        end
      end
      default: rd_state_nxt_s = R_IDLE;
    endcase
  end

  // Write path outputs: payload is always muxed from the owner, and
  // valid/ready are gated by the state so idle or non-owning sides see zeros.
  always_comb begin
    s_awaddr   = wr_grant_r ? m1_awaddr  : m0_awaddr;
    s_awid     = {wr_grant_r, (wr_grant_r ? m1_awid : m0_awid)};
    s_awlen    = wr_grant_r ? m1_awlen   : m0_awlen;
    s_awsize   = wr_grant_r ? m1_awsize  : m0_awsize;
    s_awburst  = wr_grant_r ? m1_awburst : m0_awburst;
    s_wid      = {wr_grant_r, (wr_grant_r ? m1_wid : m0_wid)};
    s_wdata    = wr_grant_r ? m1_wdata   : m0_wdata;
    s_wstrb    = wr_grant_r ? m1_wstrb   : m0_wstrb;
    s_wlast    = wr_grant_r ? m1_wlast   : m0_wlast;
    m0_bid     = s_bid[3:0];
    m1_bid     = s_bid[3:0];
    m0_bresp   = s_bresp;
    m1_bresp   = s_bresp;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    case (wr_state_r)
      W_ADDR: begin
        s_awvalid  = wr_grant_r ? m1_awvalid : m0_awvalid;
        m0_awready = ~wr_grant_r & s_awready;
        m1_awready =  wr_grant_r & s_awready;
      end
      W_DATA: begin
        s_wvalid  = wr_grant_r ? m1_wvalid : m0_wvalid;
        m0_wready = ~wr_grant_r & s_wready;
        m1_wready =  wr_grant_r & s_wready;
      end
      W_RESP: begin
        s_bready  = wr_grant_r ? m1_bready : m0_bready;
        m0_bvalid = ~wr_grant_r & s_bvalid;
        m1_bvalid =  wr_grant_r & s_bvalid;
      end
      default: begin
        s_awvalid = 1'b0;
      end
    endcase
  end

  // Read path outputs: same gating rules as the write path.
  always_comb begin
    s_araddr   = rd_grant_r ? m1_araddr  : m0_araddr;
    s_arid     = {rd_grant_r, (rd_grant_r ? m1_arid : m0_arid)};
    s_arlen    = rd_grant_r ? m1_arlen   : m0_arlen;
    s_arsize   = rd_grant_r ? m1_arsize  : m0_arsize;
    s_arburst  = rd_grant_r ? m1_arburst : m0_arburst;
    m0_rid     = s_rid[3:0];
    m1_rid     = s_rid[3:0];
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rresp   = s_rresp;
    m0_rlast   = s_rlast;
    m1_rlast   = s_rlast;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    case (rd_state_r)
      R_ADDR: begin
        s_arvalid  = rd_grant_r ? m1_arvalid : m0_arvalid;
        m0_arready = ~rd_grant_r & s_arready;
        m1_arready =  rd_grant_r & s_arready;
      end
      R_DATA: begin
        s_rready  = rd_grant_r ? m1_rready : m0_rready;
        m0_rvalid = ~rd_grant_r & s_rvalid;
        m1_rvalid =  rd_grant_r & s_rvalid;
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

  assign wr_busy  = (wr_state_r != W_IDLE);
  assign rd_busy  = (rd_state_r != R_IDLE);
  assign wr_grant = wr_grant_r;
  assign rd_grant = rd_grant_r;

endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter_2x1
// Directed bench for axi_arbiter_2x1. The bench plays both masters and the
// slave. Master-side signals are kept in 2-entry arrays indexed by master
// number. Inputs change 1 ns after a rising edge, and outputs are compared a
// further 1 ns later.
// -----------------------------------------------------------------------------
module tb_axi_arbiter_2x1;

  logic aclk = 1'b0;
  logic areset;

  logic [31:0] m_awaddr [0:1];
  logic [3:0]  m_awid   [0:1];
  logic [3:0]  m_awlen  [0:1];
  logic [2:0]  m_awsize [0:1];
  logic [1:0]  m_awburst[0:1];
  logic [1:0]  m_awvalid, m_awready;
  logic [3:0]  m_wid    [0:1];
  logic [31:0] m_wdata  [0:1];
  logic [3:0]  m_wstrb  [0:1];
  logic [1:0]  m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_bid    [0:1];
  logic [1:0]  m_bresp  [0:1];
  logic [1:0]  m_bvalid, m_bready;
  logic [31:0] m_araddr [0:1];
  logic [3:0]  m_arid   [0:1];
  logic [3:0]  m_arlen  [0:1];
  logic [2:0]  m_arsize [0:1];
  logic [1:0]  m_arburst[0:1];
  logic [1:0]  m_arvalid, m_arready;
  logic [3:0]  m_rid    [0:1];
  logic [31:0] m_rdata  [0:1];
  logic [1:0]  m_rresp  [0:1];
  logic [1:0]  m_rlast, m_rvalid, m_rready;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [4:0]  s_awid, s_wid, s_bid, s_arid, s_rid;
  logic [3:0]  s_awlen, s_wstrb, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_bresp, s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rlast, s_rvalid, s_rready;
  logic        wr_busy, rd_busy, wr_grant, rd_grant;

  int n_checks = 0;
  int n_fail   = 0;

  axi_arbiter_2x1 dut (
    .aclk(aclk), .areset(areset),
    .m0_awaddr(m_awaddr[0]), .m0_awid(m_awid[0]), .m0_awlen(m_awlen[0]),
    .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]), .m0_awvalid(m_awvalid[0]),
    .m0_awready(m_awready[0]),
    .m0_wid(m_wid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_wlast(m_wlast[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bid(m_bid[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m0_araddr(m_araddr[0]), .m0_arid(m_arid[0]), .m0_arlen(m_arlen[0]),
    .m0_arsize(m_arsize[0]), .m0_arburst(m_arburst[0]), .m0_arvalid(m_arvalid[0]),
    .m0_arready(m_arready[0]),
    .m0_rid(m_rid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
    .m0_rlast(m_rlast[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awid(m_awid[1]), .m1_awlen(m_awlen[1]),
    .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]), .m1_awvalid(m_awvalid[1]),
    .m1_awready(m_awready[1]),
    .m1_wid(m_wid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_wlast(m_wlast[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bid(m_bid[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .m1_araddr(m_araddr[1]), .m1_arid(m_arid[1]), .m1_arlen(m_arlen[1]),
    .m1_arsize(m_arsize[1]), .m1_arburst(m_arburst[1]), .m1_arvalid(m_arvalid[1]),
    .m1_arready(m_arready[1]),
    .m1_rid(m_rid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
    .m1_rlast(m_rlast[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // Free-running 100 MHz clock.
  always #5 aclk = ~aclk;

  // Hard time limit so a wedged run still reports and terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Runs one write transaction. Entry: the owner m was granted on the last
  // edge, so the path is in its address phase. Exit: 2 ns after the edge that
  // took the B handshake. stall_beat >= 0 holds s_wready low for 5 cycles at
  // that beat.
  task automatic write_burst(input bit m, input logic [31:0] addr, input logic [3:0] id,
                             input logic [3:0] len, input int stall_beat);
    bit o;
    logic [31:0] d;
    o = ~m;
    s_awready = 1'b1;
    #1;
    check_eq("aw_wr_busy", wr_busy, 1'b1);
    check_eq("aw_wr_grant", wr_grant, m);
    check_eq("aw_s_awvalid", s_awvalid, 1'b1);
    check_eq("aw_s_awaddr", s_awaddr, addr);
    check_eq("aw_s_awid", s_awid, {m, id});
    check_eq("aw_s_awlen", s_awlen, len);
    check_eq("aw_awready_owner", m_awready[m], 1'b1);
    check_eq("aw_awready_other", m_awready[o], 1'b0);
    tick();
    m_awvalid[m] = 1'b0;
    s_awready    = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = {8'hD0, 7'd0, m, i[15:0]};
      m_wvalid[m] = 1'b1;
      m_wdata[m]  = d;
      m_wid[m]    = id;
      m_wstrb[m]  = 4'hF;
      m_wlast[m]  = (i == int'(len));
      if (i == stall_beat) begin
        s_wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          check_eq("stall_s_wvalid", s_wvalid, 1'b1);
          check_eq("stall_s_wdata", s_wdata, d);
          check_eq("stall_wready_owner", m_wready[m], 1'b0);
          tick();
        end
      end
      s_wready = 1'b1;
      #1;
      check_eq("w_s_wvalid", s_wvalid, 1'b1);
      check_eq("w_s_wdata", s_wdata, d);
      check_eq("w_s_wid", s_wid, {m, id});
      check_eq("w_s_wlast", s_wlast, (i == int'(len)));
      check_eq("w_wready_owner", m_wready[m], 1'b1);
      check_eq("w_wready_other", m_wready[o], 1'b0);
      tick();
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m]  = 1'b0;
    s_wready    = 1'b0;
    // The ID MSB deliberately names the other master; routing must ignore it.
    s_bvalid    = 1'b1;
    s_bid       = {o, id};
    s_bresp     = 2'b01;
    m_bready[m] = 1'b1;
    #1;
    check_eq("b_s_wvalid", s_wvalid, 1'b0);
    check_eq("b_bvalid_owner", m_bvalid[m], 1'b1);
    check_eq("b_bvalid_other", m_bvalid[o], 1'b0);
    check_eq("b_bid", m_bid[m], id);
    check_eq("b_bresp", m_bresp[m], 2'b01);
    check_eq("b_s_bready", s_bready, 1'b1);
    tick();
    s_bvalid    = 1'b0;
    m_bready[m] = 1'b0;
    #1;
    check_eq("b_wr_busy_after", wr_busy, 1'b0);
  endtask

  // Main directed sequence.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = 32'h0; m_awid[i] = 4'h0; m_awlen[i] = 4'h0;
      m_awsize[i] = 3'd2;  m_awburst[i] = 2'b01;
      m_wid[i] = 4'h0; m_wdata[i] = 32'h0; m_wstrb[i] = 4'h0;
      m_araddr[i] = 32'h0; m_arid[i] = 4'h0; m_arlen[i] = 4'h0;
      m_arsize[i] = 3'd2;  m_arburst[i] = 2'b01;
    end
    m_awvalid = 2'b00; m_wvalid = 2'b00; m_wlast = 2'b00; m_bready = 2'b00;
    m_arvalid = 2'b00; m_rready = 2'b00;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bid = 5'h0; s_bresp = 2'b00; s_bvalid = 1'b0;
    s_rid = 5'h0; s_rdata = 32'h0; s_rresp = 2'b00; s_rlast = 1'b0; s_rvalid = 1'b0;
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    #1;
    check_eq("rst_wr_busy", wr_busy, 1'b0);
    check_eq("rst_rd_busy", rd_busy, 1'b0);
    check_eq("rst_wr_grant", wr_grant, 1'b0);
    check_eq("rst_rd_grant", rd_grant, 1'b0);
    check_eq("rst_s_awvalid", s_awvalid, 1'b0);
    check_eq("rst_s_arvalid", s_arvalid, 1'b0);
    check_eq("rst_s_bready", s_bready, 1'b0);
    check_eq("rst_s_rready", s_rready, 1'b0);

    // Single m0 write, len 3 at 0x100. Nothing reaches the slave while idle.
    tick();
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h100; m_awid[0] = 4'h3; m_awlen[0] = 4'd3;
    s_awready = 1'b1;
    #1;
    check_eq("idle_s_awvalid", s_awvalid, 1'b0);
    check_eq("idle_awready", m_awready[0], 1'b0);
    check_eq("idle_wr_busy", wr_busy, 1'b0);
    s_awready = 1'b0;
    tick();
    write_burst(1'b0, 32'h100, 4'h3, 4'd3, -1);

    // Simultaneous requests after reset: m0 wins first, and m1 is granted
    // on the edge that ends the idle cycle.
    areset = 1'b1;
    tick();
    areset = 1'b0;
    m_awvalid = 2'b11;
    m_awaddr[0] = 32'h200; m_awid[0] = 4'h1; m_awlen[0] = 4'd0;
    m_awaddr[1] = 32'h300; m_awid[1] = 4'h2; m_awlen[1] = 4'd1;
    tick();
    write_burst(1'b0, 32'h200, 4'h1, 4'd0, -1);
    tick();
    write_burst(1'b1, 32'h300, 4'h2, 4'd1, -1);
    // A lone m0 write leaves priority pointing at m1, so the next tie goes to m1.
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h400; m_awid[0] = 4'h4; m_awlen[0] = 4'd0;
    tick();
    write_burst(1'b0, 32'h400, 4'h4, 4'd0, -1);
    m_awvalid = 2'b11;
    m_awaddr[0] = 32'h410; m_awid[0] = 4'h5; m_awlen[0] = 4'd0;
    m_awaddr[1] = 32'h420; m_awid[1] = 4'h6; m_awlen[1] = 4'd0;
    tick();
    write_burst(1'b1, 32'h420, 4'h6, 4'd0, -1);
    tick();
    write_burst(1'b0, 32'h410, 4'h5, 4'd0, -1);

    // Slave back-pressure for 5 cycles at beat 2.
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h500; m_awid[0] = 4'h6; m_awlen[0] = 4'd3;
    tick();
    write_burst(1'b0, 32'h500, 4'h6, 4'd3, 2);

    // m1 read (len 1) concurrent with m0 write (len 1).
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h600; m_awid[0] = 4'h7; m_awlen[0] = 4'd1;
    m_arvalid[1] = 1'b1; m_araddr[1] = 32'h700; m_arid[1] = 4'h9; m_arlen[1] = 4'd1;
    tick();
    s_awready = 1'b1; s_arready = 1'b1;
    #1;
    check_eq("cc_rd_busy", rd_busy, 1'b1);
    check_eq("cc_rd_grant", rd_grant, 1'b1);
    check_eq("cc_wr_grant", wr_grant, 1'b0);
    check_eq("cc_s_arvalid", s_arvalid, 1'b1);
    check_eq("cc_s_araddr", s_araddr, 32'h700);
    check_eq("cc_s_arid", s_arid, 5'h19);
    check_eq("cc_s_awid", s_awid, 5'h07);
    check_eq("cc_arready_m1", m_arready[1], 1'b1);
    check_eq("cc_arready_m0", m_arready[0], 1'b0);
    check_eq("cc_awready_m0", m_awready[0], 1'b1);
    check_eq("cc_awready_m1", m_awready[1], 1'b0);
    tick();
    m_awvalid[0] = 1'b0; m_arvalid[1] = 1'b0; s_awready = 1'b0; s_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wvalid[0] = 1'b1; m_wdata[0] = 32'hA600_0000 + 32'(i); m_wid[0] = 4'h7;
      m_wlast[0] = (i == 1);
      s_wready = 1'b1;
      s_rvalid = 1'b1; s_rid = 5'h19; s_rdata = 32'hE700_0000 + 32'(i);
      s_rresp = 2'b00; s_rlast = (i == 1);
      m_rready[1] = 1'b1;
      #1;
      check_eq("cc_rvalid_m1", m_rvalid[1], 1'b1);
      check_eq("cc_rvalid_m0", m_rvalid[0], 1'b0);
      check_eq("cc_rdata_m1", m_rdata[1], 32'hE700_0000 + 32'(i));
      check_eq("cc_rid_m1", m_rid[1], 4'h9);
      check_eq("cc_rlast_m1", m_rlast[1], (i == 1));
      check_eq("cc_s_rready", s_rready, 1'b1);
      check_eq("cc_s_wvalid", s_wvalid, 1'b1);
      check_eq("cc_s_wdata", s_wdata, 32'hA600_0000 + 32'(i));
      check_eq("cc_wready_m0", m_wready[0], 1'b1);
      check_eq("cc_wready_m1", m_wready[1], 1'b0);
      tick();
    end
    m_wvalid[0] = 1'b0; m_wlast[0] = 1'b0; s_wready = 1'b0;
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready[1] = 1'b0;
    #1;
    check_eq("cc_rd_busy_done", rd_busy, 1'b0);
    check_eq("cc_wr_busy_resp", wr_busy, 1'b1);
    s_bvalid = 1'b1; s_bid = 5'h07; s_bresp = 2'b00; m_bready[0] = 1'b1;
    #1;
    check_eq("cc_bvalid_m0", m_bvalid[0], 1'b1);
    check_eq("cc_bvalid_m1", m_bvalid[1], 1'b0);
    tick();
    s_bvalid = 1'b0; m_bready[0] = 1'b0;
    #1;
    check_eq("cc_wr_busy_done", wr_busy, 1'b0);

    // Reset lands on the edge of beat 2; the burst is abandoned.
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h800; m_awid[0] = 4'hA; m_awlen[0] = 4'd3;
    tick();
    s_awready = 1'b1;
    tick();
    m_awvalid[0] = 1'b0; s_awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wvalid[0] = 1'b1; m_wdata[0] = 32'hB800_0000 + 32'(i); m_wid[0] = 4'hA;
      m_wlast[0] = 1'b0; s_wready = 1'b1;
      tick();
    end
    m_wdata[0] = 32'hB800_0002;
    #1;
    check_eq("rst_mid_s_wvalid_before", s_wvalid, 1'b1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    check_eq("rst_mid_wr_busy", wr_busy, 1'b0);
    check_eq("rst_mid_s_wvalid", s_wvalid, 1'b0);
    check_eq("rst_mid_s_awvalid", s_awvalid, 1'b0);
    check_eq("rst_mid_wready", m_wready[0], 1'b0);
    check_eq("rst_mid_wr_grant", wr_grant, 1'b0);
    m_wvalid[0] = 1'b0; s_wready = 1'b0;
    m_awvalid[1] = 1'b1; m_awaddr[1] = 32'h900; m_awid[1] = 4'hB; m_awlen[1] = 4'd2;
    tick();
    write_burst(1'b1, 32'h900, 4'hB, 4'd2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_2x1.md
AXI_ARBITER_2X1 -- requirements
Module: axi_arbiter_2x1

Interface
REQ-001 Parameter FIRST_PRI, default 0, master index given priority on the first simultaneous request after reset.
REQ-002 aclk  input  1  single clock; all logic on rising edge.
REQ-003 areset  input  1  reset, synchronous, active-high.
REQ-004 mN_awaddr/awid/awlen/awsize/awburst/awvalid (N=0,1)  input  32/4/4/3/2/1  master N write-address request.
REQ-005 mN_awready  output  1  write-address accept to master N.
REQ-006 mN_wid/wdata/wstrb/wlast/wvalid  input  4/32/4/1/1  master N write-data beat.
REQ-007 mN_wready  output  1  write-data accept to master N.
REQ-008 mN_bid/bresp/bvalid  output  4/2/1  write response to master N; mN_bready  input  1.
REQ-009 mN_araddr/arid/arlen/arsize/arburst/arvalid  input  32/4/4/3/2/1; mN_arready  output  1.
REQ-010 mN_rid/rdata/rresp/rlast/rvalid  output  4/32/2/1/1; mN_rready  input  1.
REQ-011 s_aw*/s_w*/s_ar*  output  same widths, except s_awid, s_wid, s_arid 5 bits; s_awready, s_wready, s_arready  input  1.
REQ-012 s_bid[4:0], s_bresp, s_bvalid, s_rid[4:0], s_rdata, s_rresp, s_rlast, s_rvalid  input; s_bready, s_rready  output.
REQ-013 wr_busy, rd_busy  output  1  path owned; wr_grant, rd_grant  output  1  index of current owner.

Function
REQ-014 Write and read paths: independent FSMs; may be owned concurrently by the same or different masters.
REQ-015 Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-016 W_IDLE: if any mN_awvalid, register winner into wr_grant, go W_ADDR next cycle; no s_awvalid driven in W_IDLE.
REQ-017 Winner: single requester wins; both requesting -> master indicated by wr_pri wins.
REQ-018 W_ADDR: s_aw* = granted master's aw fields; s_awid = {wr_grant, awid}; s_awvalid = granted awvalid; granted awready = s_awready; on s_awvalid&&s_awready -> W_DATA.
REQ-019 W_DATA: s_w* from granted master, s_wid = {wr_grant, wid}; granted wready = s_wready; on handshake with wlast=1 -> W_RESP; beats with wlast=0 stay.
REQ-020 W_RESP: granted mN_bvalid = s_bvalid, mN_bid = s_bid[3:0], mN_bresp = s_bresp; s_bready = granted bready; on s_bvalid&&s_bready -> W_IDLE, wr_pri <= ~wr_grant.
REQ-021 Response routing uses wr_grant only; s_bid[4] ignored.
REQ-022 Read FSM states: R_IDLE, R_ADDR, R_DATA; R_IDLE/R_ADDR mirror W_IDLE/W_ADDR on ar* with rd_grant, rd_pri, s_arid = {rd_grant, arid}.
REQ-023 R_DATA: granted rvalid/rdata/rresp/rlast/rid[3:0] from slave; s_rready = granted rready; on handshake with s_rlast=1 -> R_IDLE, rd_pri <= ~rd_grant.
REQ-024 Non-granted master: all ready and valid outputs 0 at all times; non-owned path: all s_*valid and s_*ready outputs 0.
REQ-025 Pass-through channels combinational from registered grant/state; no added beat latency; grant latency exactly one cycle from request seen in IDLE.
REQ-026 Back-to-back: return to IDLE costs one cycle; pending other master granted on that IDLE cycle's edge.
REQ-027 wr_busy = (state != W_IDLE); rd_busy = (state != R_IDLE).

Reset
REQ-028 areset high at posedge: both FSMs -> IDLE, wr_grant = rd_grant = 0, wr_pri = rd_pri = FIRST_PRI, all valid/ready outputs 0 from next cycle, even mid-burst; no partial transaction resumed.

Verification
REQ-029 m0 write len=3, addr 0x100 -> s_awid=0_xxxx, 4 beats forwarded in order, m0 gets bvalid, wr_busy low one cycle after B handshake.
REQ-030 m0 and m1 awvalid same cycle after reset, FIRST_PRI=0 -> m0 served first, m1 next; repeat -> m1 first, then m0.
REQ-031 m1 read len=1 concurrent with m0 write -> both complete, s_arid[4]=1, s_awid[4]=0, no cross-routing.
REQ-032 s_wready held low 5 cycles mid-burst -> wdata stable, granted wready low, no beat lost or duplicated.
REQ-033 areset asserted during W_DATA beat 2 -> next cycle all s_*valid=0, wr_busy=0; subsequent m1 write completes normally.
